// File: rtl/fetch_sequencer.sv
// Instruction fetch sequencer: boot-loads instruction memory, then fetches
// sequentially with stall, redirect and halt control until reset.
module fetch_sequencer #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          AW       = 10
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          ld_valid,
    input  logic [31:0]   ld_data,
    input  logic          ld_last,
    output logic          ld_ready,
    input  logic          stall,
    input  logic          redirect_valid,
    input  logic [31:0]   redirect_pc,
    input  logic          halt_req,
    output logic [AW-1:0] mem_addr,
    output logic          mem_we,
    output logic [31:0]   mem_wdata,
    input  logic [31:0]   mem_rdata,
    output logic [31:0]   if_pc,
    output logic [31:0]   if_instr,
    output logic          if_valid,
    output logic          halted,
    output logic          align_err,
    output logic [1:0]    state_dbg
);

    // Handshake: a load word transfers on a rising clk edge where
    // ld_valid && ld_ready; the offering side may change ld_data freely otherwise.
    localparam logic [1:0] ST_LOAD = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_HALT = 2'd2;

    localparam logic [AW-1:0] CNT_MAX = '1;

    logic [1:0]    state_q,     state_d;
    logic [AW-1:0] ld_cnt_q,    ld_cnt_d;
    logic [31:0]   pc_q,        pc_d;
    logic [31:0]   if_pc_q,     if_pc_d;
    logic [31:0]   if_instr_q,  if_instr_d;
    logic          if_valid_q,  if_valid_d;
    logic          align_err_q, align_err_d;
    logic          ld_accept;

    // ld_ready is gated by rst_n so it stays low while reset is held.
    assign ld_ready  = rst_n && (state_q == ST_LOAD);
    assign ld_accept = ld_valid && ld_ready;
    assign mem_we    = ld_accept;
    assign mem_wdata = ld_data;
    assign mem_addr  = (state_q == ST_LOAD) ? ld_cnt_q : pc_q[AW+1:2];

    assign if_pc     = if_pc_q;
    assign if_instr  = if_instr_q;
    assign if_valid  = if_valid_q;
    assign halted    = (state_q == ST_HALT);
    assign align_err = align_err_q;
    assign state_dbg = state_q;

    always_comb begin
        state_d     = state_q;
        ld_cnt_d    = ld_cnt_q;
        pc_d        = pc_q;
        if_pc_d     = if_pc_q;
        if_instr_d  = if_instr_q;
        if_valid_d  = if_valid_q;
        align_err_d = align_err_q;
        case (state_q)
            ST_LOAD: begin
                if_valid_d = 1'b0;
                if (ld_accept) begin
                    if (ld_cnt_q != CNT_MAX) ld_cnt_d = ld_cnt_q + 1'b1;
                    if (ld_last || (ld_cnt_q == CNT_MAX)) state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                if (halt_req) begin
                    state_d    = ST_HALT;
                    if_valid_d = 1'b0;
                end else if (redirect_valid) begin
                    // A redirect flushes the fetch register even during a stall.
                    if_valid_d = 1'b0;
                    if (redirect_pc[1:0] == 2'b00) begin
                        pc_d = redirect_pc;
                    end else begin
                        align_err_d = 1'b1;
                        state_d     = ST_HALT;
                    end
                end else if (!stall) begin
                    if_instr_d = mem_rdata;
                    if_pc_d    = pc_q;
                    if_valid_d = 1'b1;
                    pc_d       = pc_q + 32'd4;
                end
            end
            ST_HALT: begin
                if_valid_d = 1'b0;
            end
            default: begin
                state_d    = ST_LOAD;
                if_valid_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_LOAD;
            ld_cnt_q    <= '0;
            pc_q        <= RESET_PC;
            if_pc_q     <= '0;
            if_instr_q  <= '0;
            if_valid_q  <= 1'b0;
            align_err_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            ld_cnt_q    <= ld_cnt_d;
            pc_q        <= pc_d;
            if_pc_q     <= if_pc_d;
            if_instr_q  <= if_instr_d;
            if_valid_q  <= if_valid_d;
            align_err_q <= align_err_d;
        end
    end

endmodule

// File: tb/tb_fetch_sequencer.sv
// Bench for fetch_sequencer: vector table for load/run/stall/redirect/halt,
// plus hand-written sequences for reset abort, halt priority and full-depth load.
module tb_fetch_sequencer;

    logic        clk;
    logic        rst_n;
    logic        ld_valid;
    logic [31:0] ld_data;
    logic        ld_last;
    logic        ld_ready;
    logic        stall;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        halt_req;
    logic [9:0]  mem_addr;
    logic        mem_we;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic [31:0] if_pc;
    logic [31:0] if_instr;
    logic        if_valid;
    logic        halted;
    logic        align_err;
    logic [1:0]  state_dbg;

    int n_cmp;
    int n_err;
    int n_writes;

    logic [31:0] mem [0:1023];

    fetch_sequencer #(.RESET_PC(32'h0000_0000), .AW(10)) dut (
        .clk(clk), .rst_n(rst_n),
        .ld_valid(ld_valid), .ld_data(ld_data), .ld_last(ld_last), .ld_ready(ld_ready),
        .stall(stall), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .halt_req(halt_req),
        .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
        .if_pc(if_pc), .if_instr(if_instr), .if_valid(if_valid),
        .halted(halted), .align_err(align_err), .state_dbg(state_dbg)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Instruction memory model with combinational read.
    assign mem_rdata = mem[mem_addr];
    always @(posedge clk) begin
        if (mem_we) begin
            mem[mem_addr] <= mem_wdata;
            n_writes      <= n_writes + 1;
        end
    end

    typedef struct packed {
        logic        lv;
        logic [31:0] ld;
        logic        ll;
        logic        st;
        logic        rv;
        logic [31:0] rp;
        logic        hr;
        logic        e_we;
        logic [9:0]  e_addr;
        logic        e_rdy;
        logic        e_iv;
        logic [31:0] e_pc;
        logic [31:0] e_ins;
        logic        e_halt;
        logic        e_aerr;
    } vec_t;

    vec_t vecs [16];

    function automatic vec_t mk(input logic lv, input logic [31:0] ld, input logic ll,
                                input logic st, input logic rv, input logic [31:0] rp,
                                input logic hr, input logic e_we, input logic [9:0] e_addr,
                                input logic e_rdy, input logic e_iv, input logic [31:0] e_pc,
                                input logic [31:0] e_ins, input logic e_halt,
                                input logic e_aerr);
        vec_t v;
        v.lv = lv; v.ld = ld; v.ll = ll; v.st = st; v.rv = rv; v.rp = rp; v.hr = hr;
        v.e_we = e_we; v.e_addr = e_addr; v.e_rdy = e_rdy; v.e_iv = e_iv;
        v.e_pc = e_pc; v.e_ins = e_ins; v.e_halt = e_halt; v.e_aerr = e_aerr;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp = n_cmp + 1;
        if (act !== exp) begin
            n_err = n_err + 1;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic clear_inputs();
        ld_valid = 1'b0; ld_data = '0; ld_last = 1'b0; stall = 1'b0;
        redirect_valid = 1'b0; redirect_pc = '0; halt_req = 1'b0;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        ld_valid = 1'b1;
        rst_n = 1'b0;
        #1;
        check("rst ld_ready", {31'd0, ld_ready}, 32'd0);
        check("rst mem_we", {31'd0, mem_we}, 32'd0);
        check("rst halted", {31'd0, halted}, 32'd0);
        check("rst if_valid", {31'd0, if_valid}, 32'd0);
        check("rst align_err", {31'd0, align_err}, 32'd0);
        check("rst state", {30'd0, state_dbg}, 32'd0);
        clear_inputs();
        @(negedge clk);
        rst_n = 1'b1;
        step();
    endtask

    task automatic load_word(input logic [31:0] d, input logic last);
        ld_valid = 1'b1; ld_data = d; ld_last = last;
        step();
        clear_inputs();
    endtask

    initial begin
        n_cmp = 0; n_err = 0; n_writes = 0;
        for (int i = 0; i < 1024; i++) mem[i] = '0;
        clear_inputs();
        rst_n = 1'b0;
        ld_valid = 1'b1;
        #2;
        check("init ld_ready", {31'd0, ld_ready}, 32'd0);
        check("init mem_we", {31'd0, mem_we}, 32'd0);
        check("init if_pc", if_pc, 32'd0);
        check("init if_instr", if_instr, 32'd0);
        check("init if_valid", {31'd0, if_valid}, 32'd0);
        check("init halted", {31'd0, halted}, 32'd0);
        check("init align_err", {31'd0, align_err}, 32'd0);
        ld_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        step();
        check("post-rst ld_ready", {31'd0, ld_ready}, 32'd1);

        //              lv ld            ll st rv rp          hr  we addr rdy iv pc         ins           hlt aer
        vecs[0]  = mk(1, 32'h11, 0, 0, 0, 32'h0, 0,  1, 10'd0, 1, 0, 32'h0, 32'h00, 0, 0);
        vecs[1]  = mk(0, 32'hFF, 0, 0, 0, 32'h0, 0,  0, 10'd1, 1, 0, 32'h0, 32'h00, 0, 0);
        vecs[2]  = mk(1, 32'h22, 0, 0, 0, 32'h0, 0,  1, 10'd1, 1, 0, 32'h0, 32'h00, 0, 0);
        vecs[3]  = mk(0, 32'hEE, 0, 0, 0, 32'h0, 0,  0, 10'd2, 1, 0, 32'h0, 32'h00, 0, 0);
        vecs[4]  = mk(1, 32'h33, 1, 0, 0, 32'h0, 0,  1, 10'd2, 1, 0, 32'h0, 32'h00, 0, 0);
        vecs[5]  = mk(0, 32'h0,  0, 0, 0, 32'h0, 0,  0, 10'd0, 0, 1, 32'h0, 32'h11, 0, 0);
        vecs[6]  = mk(0, 32'h0,  0, 0, 0, 32'h0, 0,  0, 10'd1, 0, 1, 32'h4, 32'h22, 0, 0);
        vecs[7]  = mk(0, 32'h0,  0, 1, 0, 32'h0, 0,  0, 10'd2, 0, 1, 32'h4, 32'h22, 0, 0);
        vecs[8]  = mk(0, 32'h0,  0, 1, 0, 32'h0, 0,  0, 10'd2, 0, 1, 32'h4, 32'h22, 0, 0);
        vecs[9]  = mk(0, 32'h0,  0, 0, 0, 32'h0, 0,  0, 10'd2, 0, 1, 32'h8, 32'h33, 0, 0);
        vecs[10] = mk(0, 32'h0,  0, 1, 1, 32'h0, 0,  0, 10'd3, 0, 0, 32'h8, 32'h33, 0, 0);
        vecs[11] = mk(0, 32'h0,  0, 0, 0, 32'h0, 0,  0, 10'd0, 0, 1, 32'h0, 32'h11, 0, 0);
        vecs[12] = mk(0, 32'h0,  0, 0, 0, 32'h0, 0,  0, 10'd1, 0, 1, 32'h4, 32'h22, 0, 0);
        vecs[13] = mk(0, 32'h0,  0, 0, 1, 32'h6, 0,  0, 10'd2, 0, 0, 32'h4, 32'h22, 1, 1);
        vecs[14] = mk(1, 32'h55, 1, 0, 0, 32'h0, 0,  0, 10'd2, 0, 0, 32'h4, 32'h22, 1, 1);
        vecs[15] = mk(0, 32'h0,  0, 1, 1, 32'h0, 1,  0, 10'd2, 0, 0, 32'h4, 32'h22, 1, 1);

        for (int i = 0; i < 16; i++) begin
            ld_valid = vecs[i].lv; ld_data = vecs[i].ld; ld_last = vecs[i].ll;
            stall = vecs[i].st; redirect_valid = vecs[i].rv; redirect_pc = vecs[i].rp;
            halt_req = vecs[i].hr;
            #1;
            check($sformatf("v%0d mem_we", i), {31'd0, mem_we}, {31'd0, vecs[i].e_we});
            check($sformatf("v%0d mem_addr", i), {22'd0, mem_addr}, {22'd0, vecs[i].e_addr});
            check($sformatf("v%0d ld_ready", i), {31'd0, ld_ready}, {31'd0, vecs[i].e_rdy});
            if (vecs[i].e_we) check($sformatf("v%0d mem_wdata", i), mem_wdata, vecs[i].ld);
            step();
            check($sformatf("v%0d if_valid", i), {31'd0, if_valid}, {31'd0, vecs[i].e_iv});
            check($sformatf("v%0d if_pc", i), if_pc, vecs[i].e_pc);
            check($sformatf("v%0d if_instr", i), if_instr, vecs[i].e_ins);
            check($sformatf("v%0d halted", i), {31'd0, halted}, {31'd0, vecs[i].e_halt});
            check($sformatf("v%0d align_err", i), {31'd0, align_err}, {31'd0, vecs[i].e_aerr});
        end
        clear_inputs();
        check("load write count", n_writes, 32'd3);
        check("mem[0]", mem[0], 32'h11);
        check("mem[1]", mem[1], 32'h22);
        check("mem[2]", mem[2], 32'h33);

        // Reset out of HALT, then abort a load mid-way; loading restarts at 0.
        do_reset();
        check("halt-rst ld_ready", {31'd0, ld_ready}, 32'd1);
        check("halt-rst addr", {22'd0, mem_addr}, 32'd0);
        load_word(32'h11, 1'b0);
        check("midload addr", {22'd0, mem_addr}, 32'd1);
        do_reset();
        check("abort addr", {22'd0, mem_addr}, 32'd0);
        load_word(32'h11, 1'b0);
        load_word(32'h22, 1'b0);
        load_word(32'h33, 1'b1);
        check("run0 if_valid", {31'd0, if_valid}, 32'd0);
        check("run0 addr", {22'd0, mem_addr}, 32'd0);
        step();
        check("A f0 pc", if_pc, 32'h0);
        check("A f0 instr", if_instr, 32'h11);
        step();
        check("A f1 pc", if_pc, 32'h4);
        halt_req = 1'b1; redirect_valid = 1'b1; redirect_pc = 32'h0;
        step();
        clear_inputs();
        check("A halt halted", {31'd0, halted}, 32'd1);
        check("A halt if_valid", {31'd0, if_valid}, 32'd0);
        check("A halt pc held", {22'd0, mem_addr}, 32'd2);
        check("A halt no aerr", {31'd0, align_err}, 32'd0);
        step();
        check("A halt sticky", {31'd0, halted}, 32'd1);

        // Full-depth load without ld_last, then alias redirect.
        do_reset();
        for (int i = 0; i < 1024; i++) begin
            ld_valid = 1'b1; ld_data = 32'hC0DE_0000 | i; ld_last = 1'b0;
            if (i == 1023) begin
                #1;
                check("B last addr", {22'd0, mem_addr}, 32'd1023);
                check("B last ready", {31'd0, ld_ready}, 32'd1);
            end
            step();
        end
        clear_inputs();
        #1;
        check("B run ld_ready", {31'd0, ld_ready}, 32'd0);
        check("B run addr", {22'd0, mem_addr}, 32'd0);
        check("B mem[1023]", mem[1023], 32'hC0DE_03FF);
        step();
        check("B f0 instr", if_instr, 32'hC0DE_0000);
        redirect_valid = 1'b1; redirect_pc = 32'h0000_1000;
        step();
        clear_inputs();
        check("B flush if_valid", {31'd0, if_valid}, 32'd0);
        step();
        check("B alias if_valid", {31'd0, if_valid}, 32'd1);
        check("B alias if_pc", if_pc, 32'h0000_1000);
        check("B alias instr", if_instr, 32'hC0DE_0000);
        step();
        check("B next if_pc", if_pc, 32'h0000_1004);
        check("B next instr", if_instr, 32'hC0DE_0001);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
